// File: rtl/alarm_sequencer.sv
// Arm/disarm sequencer with exit and entry delays, latched alarm, pulsed siren
// and saturating alarm-event counter. Optional panic input: ALARM_PANIC_EN.
module alarm_sequencer #(
   parameter int EXIT_DLY  = 16,
   parameter int ENTRY_DLY = 8,
   parameter int SIREN_DIV = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic             arm,
   input  logic             disarm,
   input  logic             panic,
   output logic [2:0]       state,
   output logic             armed,
   output logic             alarm_active,
   output logic             siren,
   output logic [CNT_W-1:0] event_cnt
);

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_EXIT     = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4
   } state_t;

   localparam logic [7:0]       EXIT_LOAD  = 8'(EXIT_DLY - 1);
   localparam logic [7:0]       ENTRY_LOAD = 8'(ENTRY_DLY - 1);
   localparam logic [7:0]       DIV_LAST   = 8'(SIREN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_t           state_reg, state_next;
   logic [7:0]       timer_reg, timer_next;
   logic [7:0]       presc_reg, presc_next;
   logic             siren_reg, siren_next;
   logic             armed_reg, armed_next;
   logic             alarm_reg, alarm_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             enter_alarm;
   logic             panic_req;

`ifdef ALARM_PANIC_EN
   assign panic_req = panic;
`else
   logic unused_panic;
   assign panic_req    = 1'b0;
   assign unused_panic = panic;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_DISARMED;
         timer_reg <= 8'd0;
         presc_reg <= 8'd0;
         siren_reg <= 1'b0;
         armed_reg <= 1'b0;
         alarm_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         presc_reg <= presc_next;
         siren_reg <= siren_next;
         armed_reg <= armed_next;
         alarm_reg <= alarm_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Branch order encodes priority: disarm, panic, timer expiry, trig, arm.
   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      case (state_reg)
         S_DISARMED: begin
            if (!disarm && panic_req) begin
               state_next = S_ALARM;
            end else if (!disarm && arm) begin
               state_next = S_EXIT;
               timer_next = EXIT_LOAD;
            end
         end
         S_EXIT: begin
            if (disarm)                  state_next = S_DISARMED;
            else if (panic_req)          state_next = S_ALARM;
            else if (timer_reg == 8'd0)  state_next = S_ARMED;
            else                         timer_next = timer_reg - 8'd1;
         end
         S_ARMED: begin
            if (disarm) begin
               state_next = S_DISARMED;
            end else if (panic_req) begin
               state_next = S_ALARM;
            end else if (trig) begin
               state_next = S_ENTRY;
               timer_next = ENTRY_LOAD;
            end
         end
         S_ENTRY: begin
            if (disarm)                  state_next = S_DISARMED;
            else if (panic_req)          state_next = S_ALARM;
            else if (timer_reg == 8'd0)  state_next = S_ALARM;
            else                         timer_next = timer_reg - 8'd1;
         end
         S_ALARM: begin
            if (disarm) state_next = S_DISARMED;
         end
         default: state_next = S_DISARMED;
      endcase
   end

   always_comb begin
      enter_alarm = (state_next == S_ALARM) && (state_reg != S_ALARM);
      presc_next  = 8'd0;
      siren_next  = 1'b0;
      cnt_next    = cnt_reg;
      armed_next  = (state_next == S_ARMED) || (state_next == S_ENTRY);
      alarm_next  = (state_next == S_ALARM);
      // Siren starts high on the first alarm cycle, then toggles each SIREN_DIV cycles.
      if (state_next == S_ALARM) begin
         if (enter_alarm) begin
            siren_next = 1'b1;
         end else if (presc_reg == DIV_LAST) begin
            siren_next = ~siren_reg;
         end else begin
            presc_next = presc_reg + 8'd1;
            siren_next = siren_reg;
         end
      end
      if (enter_alarm && (cnt_reg != CNT_MAX)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   assign state        = state_reg;
   assign armed        = armed_reg;
   assign alarm_active = alarm_reg;
   assign siren        = siren_reg;
   assign event_cnt    = cnt_reg;

endmodule
